// File: rtl/auto_counter_pkg.sv
// -----------------------------------------------------------------------------
// auto_counter_pkg
// Shared definitions for the auto-counting BCD display block:
//   - bcd_t     : one BCD nibble
//   - GLYPH_0..9: active-low seven-segment glyphs {dp,g,f,e,d,c,b,a}, dp off
//   - SEG_BLANK : all segments off (also used for any non-decimal nibble)
// -----------------------------------------------------------------------------
package auto_counter_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [7:0] GLYPH_0   = 8'hC0;
    localparam logic [7:0] GLYPH_1   = 8'hF9;
    localparam logic [7:0] GLYPH_2   = 8'hA4;
    localparam logic [7:0] GLYPH_3   = 8'hB0;
    localparam logic [7:0] GLYPH_4   = 8'h99;
    localparam logic [7:0] GLYPH_5   = 8'h92;
    localparam logic [7:0] GLYPH_6   = 8'h82;
    localparam logic [7:0] GLYPH_7   = 8'hF8;
    localparam logic [7:0] GLYPH_8   = 8'h80;
    localparam logic [7:0] GLYPH_9   = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg_decoder.sv
// -----------------------------------------------------------------------------
// seg_decoder
// Combinational BCD nibble to active-low seven-segment glyph.
// Ports:
//   nib   in   4  BCD digit
//   glyph out  8  active-low {dp,g,f,e,d,c,b,a}; dp always off, >9 shows blank
// -----------------------------------------------------------------------------
module seg_decoder
    import auto_counter_pkg::*;
(
    input  bcd_t       nib,
    output logic [7:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        case (nib)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            default: glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/auto_counter_disp.sv
// -----------------------------------------------------------------------------
// auto_counter_disp
// Free-running BCD up/down counter with a multiplexed seven-segment display.
// A tick divider steps the count every TICK_DIV cycles; a scan divider walks
// the display digit index every SCAN_DIV cycles.
//
// Parameters: DIGITS (1..8), TICK_DIV (>=2), SCAN_DIV (>=1)
// Ports:
//   CLK      in   1         clock, rising edge
//   reset    in   1         synchronous active-high reset
//   en       in   1         count enable
//   up       in   1         1 = increment, 0 = decrement
//   load     in   1         synchronous load of load_val
//   load_val in   4*DIGITS  BCD preset, nibble 0 least significant
//   count    out  4*DIGITS  registered BCD count
//   wrap     out  1         one-cycle pulse when a rollover value appears
//   pos      out  DIGITS    active-low one-hot digit select
//   seg      out  8         active-low segments {dp,g,f,e,d,c,b,a}
//
// Build option: define AUTO_CNT_BLANK_EN to blank leading zero digits
// (digit 0 is never blanked).
// -----------------------------------------------------------------------------
module auto_counter_disp
    import auto_counter_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 4194304,
    parameter int SCAN_DIV = 32768
)(
    input  logic                CLK,
    input  logic                reset,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                wrap,
    output logic [DIGITS-1:0]   pos,
    output logic [7:0]          seg
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] POS_RST   = ~(DIGITS'(1));

    // Non-decimal nibbles in a preset load as zero so count is always valid BCD.
    function automatic logic [4*DIGITS-1:0] sanitize(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++)
            r[i*4 +: 4] = (v[i*4 +: 4] > 4'd9) ? 4'd0 : v[i*4 +: 4];
        return r;
    endfunction

    // Decimal +/-1 with ripple carry/borrow; MSB of the result is the rollover.
    function automatic logic [4*DIGITS:0] bcd_step(input logic [4*DIGITS-1:0] v,
                                                   input logic dir_up);
        logic [4*DIGITS-1:0] r;
        logic                c;
        bcd_t                d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[i*4 +: 4];
            if (c) begin
                if (dir_up) begin
                    if (d == 4'd9) r[i*4 +: 4] = 4'd0;
                    else begin
                        r[i*4 +: 4] = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) r[i*4 +: 4] = 4'd9;
                    else begin
                        r[i*4 +: 4] = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return {c, r};
    endfunction

    logic [TICK_W-1:0]   tick_cnt, tick_nxt;
    logic [SCAN_W-1:0]   scan_cnt, scan_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic                tick, scan_tc;
    logic [4*DIGITS-1:0] count_nxt;
    logic                wrap_nxt;
    logic [DIGITS-1:0]   pos_nxt;
    bcd_t                sel_nib;
    logic [7:0]          glyph;
    logic [7:0]          seg_nxt;

    // Next-state for counting; load beats a coincident tick, which is dropped.
    always_comb begin
        tick      = (tick_cnt == TICK_LAST);
        tick_nxt  = tick ? '0 : tick_cnt + 1'b1;
        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (load) begin
            count_nxt = sanitize(load_val);
            tick_nxt  = '0;
        end else if (tick && en) begin
            {wrap_nxt, count_nxt} = bcd_step(count, up);
        end
    end

    // Next-state for scanning.
    always_comb begin
        scan_tc  = (scan_cnt == SCAN_LAST);
        scan_nxt = scan_tc ? '0 : scan_cnt + 1'b1;
        idx_nxt  = idx;
        if (scan_tc)
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end

    // Display values are derived from the next count/index so that the
    // registered pos/seg always agree with the registered count and index.
    always_comb begin
        sel_nib = 4'd0;
        pos_nxt = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                sel_nib    = count_nxt[i*4 +: 4];
                pos_nxt[i] = 1'b0;
            end
        end
    end

    seg_decoder u_dec (
        .nib   (sel_nib),
        .glyph (glyph)
    );

`ifdef AUTO_CNT_BLANK_EN
    logic blank_sel;
    logic nz_seen;

    // Walk from the top digit down; a digit is blank while every digit at or
    // above it is zero.
    always_comb begin
        nz_seen   = 1'b0;
        blank_sel = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (count_nxt[i*4 +: 4] != 4'd0) nz_seen = 1'b1;
            if ((idx_nxt == IDX_W'(i)) && (i != 0) && !nz_seen) blank_sel = 1'b1;
        end
    end

    assign seg_nxt = blank_sel ? SEG_BLANK : glyph;
`else
    assign seg_nxt = glyph;
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            tick_cnt <= '0;
            scan_cnt <= '0;
            idx      <= '0;
            count    <= '0;
            wrap     <= 1'b0;
            pos      <= POS_RST;
            seg      <= GLYPH_0;
        end else begin
            tick_cnt <= tick_nxt;
            scan_cnt <= scan_nxt;
            idx      <= idx_nxt;
            count    <= count_nxt;
            wrap     <= wrap_nxt;
            pos      <= pos_nxt;
            seg      <= seg_nxt;
        end
    end

endmodule
